// File: rtl/fetch_buffer_pkg.sv
// Shared types and widths for the I-cache to decode fetch buffer.
package fetch_buffer_pkg;

    localparam int XLEN    = 32;
    localparam int FETCH_W = 64;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-response and decode handshake bundle around the fetch buffer.
interface fetch_buffer_if;
    import fetch_buffer_pkg::*;

    logic               fetch_valid_i;
    logic               fetch_ready_o;
    logic [XLEN-1:0]    fetch_pc_i;
    logic [FETCH_W-1:0] fetch_data_i;
    logic               dec_valid_o;
    logic               dec_ready_i;
    logic [XLEN-1:0]    dec_pc_o;
    logic [31:0]        dec_instr_o;

    // slave: the buffer itself; master: I-cache side plus decoder side
    modport slave (
        input  fetch_valid_i, fetch_pc_i, fetch_data_i, dec_ready_i,
        output fetch_ready_o, dec_valid_o, dec_pc_o, dec_instr_o
    );
    modport master (
        output fetch_valid_i, fetch_pc_i, fetch_data_i, dec_ready_i,
        input  fetch_ready_o, dec_valid_o, dec_pc_o, dec_instr_o
    );
endinterface

// File: rtl/fetch_buffer.sv
// Circular {pc, instr} buffer: takes 64-bit fetch blocks, hands one word per cycle to decode.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    fetch_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, free, npush;
    logic            push, pop, aligned;

    assign free    = CW'(DEPTH) - count;
    // Ready is purely a function of registered occupancy: room for a whole block.
    assign bus.fetch_ready_o = free >= CW'(2);

    assign aligned = ~bus.fetch_pc_i[2];
    assign npush   = aligned ? CW'(2) : CW'(1);
    assign push    = bus.fetch_valid_i & bus.fetch_ready_o & ~flush_i;
    assign pop     = bus.dec_valid_o & bus.dec_ready_i & ~flush_i;

    assign bus.dec_valid_o = count != '0;
    assign bus.dec_pc_o    = mem[rd_ptr].pc;
    assign bus.dec_instr_o = mem[rd_ptr].instr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                if (aligned) begin
                    mem[wr_ptr]            <= '{pc: bus.fetch_pc_i, instr: bus.fetch_data_i[31:0]};
                    mem[wr_ptr + PW'(1)]   <= '{pc: bus.fetch_pc_i + XLEN'(4), instr: bus.fetch_data_i[63:32]};
                    wr_ptr                 <= wr_ptr + PW'(2);
                end else begin
                    // Branch into the upper half: the lower word is not on the path.
                    mem[wr_ptr] <= '{pc: bus.fetch_pc_i, instr: bus.fetch_data_i[63:32]};
                    wr_ptr      <= wr_ptr + PW'(1);
                end
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (push ? npush : CW'(0)) - CW'(pop);
        end
    end

    a_pc_align: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.fetch_valid_i |-> bus.fetch_pc_i[1:0] == 2'b00);
    a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
        count <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: model queues expected entries, negedge monitor compares.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    fetch_buffer_if bus();

    fetch_buffer #(.DEPTH(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int           n_chk  = 0;
    int           n_fail = 0;
    fetch_entry_t q[$];
    int           mcount = 0;
    int           np;
    bit           pp;
    bit           accepted = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: occupancy and expected entries, updated on the active edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mcount   = 0;
            accepted = 1'b0;
        end else if (flush) begin
            q.delete();
            mcount   = 0;
            accepted = 1'b0;
        end else begin
            accepted = bus.fetch_valid_i && ((4 - mcount) >= 2);
            pp       = (mcount != 0) && bus.dec_ready_i;
            np       = 0;
            if (accepted) begin
                if (!bus.fetch_pc_i[2]) begin
                    q.push_back('{pc: bus.fetch_pc_i, instr: bus.fetch_data_i[31:0]});
                    q.push_back('{pc: bus.fetch_pc_i + 32'd4, instr: bus.fetch_data_i[63:32]});
                    np = 2;
                end else begin
                    q.push_back('{pc: bus.fetch_pc_i, instr: bus.fetch_data_i[63:32]});
                    np = 1;
                end
            end
            mcount = mcount + np - (pp ? 1 : 0);
        end
    end

    // Monitor: compare outputs mid-cycle, consume the head on a real pop.
    always @(negedge clk) begin
        if (!rst) begin
            chk("dec_valid", 64'(bus.dec_valid_o), 64'(mcount != 0));
            chk("fetch_ready", 64'(bus.fetch_ready_o), 64'((4 - mcount) >= 2));
            if (bus.dec_valid_o) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc %h with empty scoreboard", bus.dec_pc_o);
                end else begin
                    chk("dec_pc", 64'(bus.dec_pc_o), 64'(q[0].pc));
                    chk("dec_instr", 64'(bus.dec_instr_o), 64'(q[0].instr));
                    if (bus.dec_ready_i && !flush) void'(q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit fv, input logic [31:0] pc, input logic [63:0] d, input bit dr);
        bus.fetch_valid_i = fv;
        bus.fetch_pc_i    = pc;
        bus.fetch_data_i  = d;
        bus.dec_ready_i   = dr;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dec_valid"}, 64'(bus.dec_valid_o), 64'd0);
        chk({tag, "_fetch_ready"}, 64'(bus.fetch_ready_o), 64'd1);
        chk({tag, "_dec_pc"}, 64'(bus.dec_pc_o), 64'd0);
        chk({tag, "_dec_instr"}, 64'(bus.dec_instr_o), 64'd0);
    endtask

    logic [31:0] cpc;

    initial begin
        drive(1'b0, 32'h0, 64'h0, 1'b0);
        rst = 1'b1;
        repeat (2) step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        // aligned block: two words, head visible the cycle after the push
        drive(1'b1, 32'h8000_0000, 64'h0000_0513_0010_0093, 1'b0);
        step();
        drive(1'b0, 32'h0, 64'h0, 1'b0);
        #1;
        chk("aligned_pc0", 64'(bus.dec_pc_o), 64'h8000_0000);
        chk("aligned_instr0", 64'(bus.dec_instr_o), 64'h0010_0093);
        step();
        bus.dec_ready_i = 1'b1;
        step();
        bus.dec_ready_i = 1'b0;
        #1;
        chk("aligned_pc1", 64'(bus.dec_pc_o), 64'h8000_0004);
        chk("aligned_instr1", 64'(bus.dec_instr_o), 64'h0000_0513);
        bus.dec_ready_i = 1'b1;
        step();
        drive(1'b0, 32'h0, 64'h0, 1'b0);
        step();

        // misaligned block: only the upper word enters
        drive(1'b1, 32'h8000_0004, 64'hDEAD_BEEF_1234_5678, 1'b0);
        step();
        drive(1'b0, 32'h0, 64'h0, 1'b1);
        #1;
        chk("misaligned_pc", 64'(bus.dec_pc_o), 64'h8000_0004);
        chk("misaligned_instr", 64'(bus.dec_instr_o), 64'hDEAD_BEEF);
        step();
        #1;
        chk("misaligned_single", 64'(bus.dec_valid_o), 64'd0);
        drive(1'b0, 32'h0, 64'h0, 1'b0);
        step();

        // fill to DEPTH, then free one and two slots
        drive(1'b1, 32'h0000_1000, 64'h1111_1004_1111_1000, 1'b0);
        step();
        drive(1'b1, 32'h0000_1008, 64'h1111_100C_1111_1008, 1'b0);
        step();
        drive(1'b0, 32'h0, 64'h0, 1'b0);
        #1;
        chk("full_ready", 64'(bus.fetch_ready_o), 64'd0);
        step();
        bus.dec_ready_i = 1'b1;
        step();
        bus.dec_ready_i = 1'b0;
        #1;
        chk("free1_ready", 64'(bus.fetch_ready_o), 64'd0);
        step();
        bus.dec_ready_i = 1'b1;
        step();
        #1;
        chk("free2_ready", 64'(bus.fetch_ready_o), 64'd1);
        repeat (3) step();
        bus.dec_ready_i = 1'b0;
        step();

        // streaming: push whenever allowed, pop every cycle; pointers wrap
        cpc = 32'h0000_2000;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, cpc, {32'hA000_0000 | (cpc + 32'd4), 32'hA000_0000 | cpc}, 1'b1);
            step();
            if (accepted) cpc = cpc + 32'd8;
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1);
        repeat (6) step();
        chk("stream_drained", 64'(q.size()), 64'd0);
        bus.dec_ready_i = 1'b0;
        step();

        // flush with a concurrent push attempt and pop request, count = 3
        drive(1'b1, 32'h0000_3000, 64'h3333_3004_3333_3000, 1'b0);
        step();
        drive(1'b1, 32'h0000_3014, 64'h3333_3014_3333_3010, 1'b0);
        step();
        drive(1'b1, 32'h0000_4000, 64'h4444_4004_4444_4000, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 1'b1);
        #1;
        chk("flush_dec_valid", 64'(bus.dec_valid_o), 64'd0);
        chk("flush_fetch_ready", 64'(bus.fetch_ready_o), 64'd1);
        repeat (3) step();

        // reset while holding data
        drive(1'b1, 32'h0000_5000, 64'h5555_5004_5555_5000, 1'b0);
        step();
        drive(1'b0, 32'h0, 64'h0, 1'b0);
        step();
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrun_reset");
        step();
        rst = 1'b0;
        repeat (2) step();

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
